// File: rtl/rotate_step_ctrl.sv
// Enable generator for the one-hot rotator. Two buttons are synchronized and debounced, then a
// RUN/PAUSE FSM turns them into single-cycle en pulses: from a prescaler in RUN, one per step press in PAUSE.
module rotate_step_ctrl #(
    parameter int DIV = 50_000_000,
    parameter int DEB = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_run,
    input  logic btn_step,
    output logic en,
    output logic running
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB - 1);

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    logic [1:0] btn_raw;
    logic [1:0] press;
    logic       run_press;
    logic       step_press;

    assign btn_raw    = {btn_step, btn_run};
    assign run_press  = press[0];
    assign step_press = press[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_q, sync1_d;
            logic          sync2_q, sync2_d;
            logic          deb_q, deb_d;
            logic          deb_prev_q, deb_prev_d;
            logic [CW-1:0] cnt_q, cnt_d;

            // The counter only runs while the synchronized input disagrees with the debounced
            // value, so any excursion shorter than DEB cycles restarts from zero.
            always_comb begin
                sync1_d    = btn_raw[gi];
                sync2_d    = sync1_q;
                deb_d      = deb_q;
                deb_prev_d = deb_q;
                cnt_d      = '0;
                if (sync2_q != deb_q) begin
                    if (cnt_q == DEB_LAST) begin
                        deb_d = ~deb_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q    <= 1'b0;
                    sync2_q    <= 1'b0;
                    deb_q      <= 1'b0;
                    deb_prev_q <= 1'b0;
                    cnt_q      <= '0;
                end else begin
                    sync1_q    <= sync1_d;
                    sync2_q    <= sync2_d;
                    deb_q      <= deb_d;
                    deb_prev_q <= deb_prev_d;
                    cnt_q      <= cnt_d;
                end
            end

            assign press[gi] = deb_q & ~deb_prev_q;
        end
    endgenerate

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          en_q, en_d;
    logic          running_q, running_d;

    // A run press always wins over a simultaneous step press; a prescaler pulse that is
    // already due when RUN is left is still delivered.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        en_d    = 1'b0;
        case (state_q)
            ST_PAUSE: begin
                pre_d = '0;
                if (run_press) begin
                    state_d = ST_RUN;
                end else if (step_press) begin
                    en_d = 1'b1;
                end
            end
            ST_RUN: begin
                en_d = (pre_q == PRE_LAST);
                if (run_press) begin
                    state_d = ST_PAUSE;
                    pre_d   = '0;
                end else if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_PAUSE;
                pre_d   = '0;
            end
        endcase
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_PAUSE;
            pre_q     <= '0;
            en_q      <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            en_q      <= en_d;
            running_q <= running_d;
        end
    end

    assign en      = en_q;
    assign running = running_q;

endmodule

// File: tb/tb_rotate_step_ctrl.sv
// Directed bench for rotate_step_ctrl with DIV=4, DEB=4; outputs are sampled 1 time unit after each rising edge.
module tb_rotate_step_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_run = 1'b0;
    logic btn_step = 1'b0;
    logic en;
    logic running;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int dbl_cnt = 0;
    int bad_rst = 0;
    logic en_prev = 1'b0;

    rotate_step_ctrl #(.DIV(4), .DEB(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_run (btn_run),
        .btn_step(btn_step),
        .en      (en),
        .running (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance n rising edges, sampling outputs shortly after each one.
    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (en === 1'b1) en_cnt++;
            if (en === 1'b1 && en_prev === 1'b1) dbl_cnt++;
            en_prev = en;
        end
    endtask

    initial begin
        // 1: reset held with button activity
        #2;
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        for (int i = 0; i < 10; i++) begin
            btn_run  = i[0];
            btn_step = ~i[0];
            step_n(1);
            if (en !== 1'b0 || running !== 1'b0) bad_rst++;
        end
        chk("rst_hold_outputs", 32'(bad_rst), 32'd0);
        btn_run = 1'b0;
        btn_step = 1'b0;
        step_n(2);
        rst_n = 1'b1;
        en_cnt = 0;
        step_n(12);
        chk("post_rst_no_en", 32'(en_cnt), 32'd0);
        chk("post_rst_pause", 32'(running), 32'd0);

        // 2: single step in PAUSE, held 20 cycles
        btn_step = 1'b1;
        step_n(6);
        chk("step_before", 32'(en), 32'd0);
        step_n(1);
        chk("step_pulse", 32'(en), 32'd1);
        step_n(1);
        chk("step_one_cycle", 32'(en), 32'd0);
        step_n(12);
        chk("step_hold_count", 32'(en_cnt), 32'd1);
        btn_step = 1'b0;
        step_n(12);
        chk("step_release", 32'(en_cnt), 32'd1);

        // 3: RUN with periodic pulses, then pause
        btn_run = 1'b1;
        step_n(6);
        chk("run_not_yet", 32'(running), 32'd0);
        step_n(1);
        chk("run_entered", 32'(running), 32'd1);
        step_n(3);
        chk("run_first_wait", 32'(en), 32'd0);
        step_n(1);
        chk("run_first_pulse", 32'(en), 32'd1);
        btn_run = 1'b0;
        en_cnt = 0;
        step_n(48);
        chk("run_48_cycles", 32'(en_cnt), 32'd12);
        btn_run = 1'b1;
        en_cnt = 0;
        step_n(7);
        chk("pause_entered", 32'(running), 32'd0);
        chk("pause_last_pulses", 32'(en_cnt), 32'd1);
        btn_run = 1'b0;
        en_cnt = 0;
        step_n(20);
        chk("pause_quiet", 32'(en_cnt), 32'd0);

        // 4: glitch rejection, then minimum-length press
        btn_step = 1'b1;
        step_n(3);
        btn_step = 1'b0;
        step_n(20);
        chk("glitch_rejected", 32'(en_cnt), 32'd0);
        btn_step = 1'b1;
        step_n(4);
        btn_step = 1'b0;
        step_n(3);
        chk("min_press_pulse", 32'(en), 32'd1);
        step_n(20);
        chk("min_press_count", 32'(en_cnt), 32'd1);

        // 5: simultaneous presses, then run press while count is at DIV-1
        btn_run = 1'b1;
        btn_step = 1'b1;
        en_cnt = 0;
        step_n(7);
        chk("both_running", 32'(running), 32'd1);
        chk("both_no_step", 32'(en_cnt), 32'd0);
        btn_run = 1'b0;
        btn_step = 1'b0;
        step_n(9);
        btn_run = 1'b1;
        en_cnt = 0;
        step_n(6);
        chk("final_pre_run", 32'(running), 32'd1);
        chk("final_pre_en", 32'(en), 32'd0);
        step_n(1);
        chk("final_pulse", 32'(en), 32'd1);
        chk("final_paused", 32'(running), 32'd0);
        chk("final_count", 32'(en_cnt), 32'd2);
        btn_run = 1'b0;
        en_cnt = 0;
        step_n(20);
        chk("final_quiet", 32'(en_cnt), 32'd0);

        // 6: reset in RUN at count 2, and reset during a pulse
        btn_run = 1'b1;
        step_n(7);
        btn_run = 1'b0;
        chk("rst6_running", 32'(running), 32'd1);
        step_n(2);
        rst_n = 1'b0;
        #1;
        chk("rst6_running_kill", 32'(running), 32'd0);
        chk("rst6_en_kill", 32'(en), 32'd0);
        step_n(3);
        rst_n = 1'b1;
        en_cnt = 0;
        step_n(12);
        chk("rst6_paused", 32'(running), 32'd0);
        chk("rst6_no_pulse", 32'(en_cnt), 32'd0);
        btn_run = 1'b1;
        step_n(7);
        btn_run = 1'b0;
        step_n(4);
        chk("rst6_pulse_live", 32'(en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst6_pulse_kill", 32'(en), 32'd0);
        step_n(2);
        rst_n = 1'b1;
        en_cnt = 0;
        step_n(12);
        chk("rst6_no_owed", 32'(en_cnt), 32'd0);
        btn_step = 1'b1;
        step_n(10);
        btn_step = 1'b0;
        step_n(10);
        chk("rst6_step_works", 32'(en_cnt), 32'd1);

        chk("no_double_en", 32'(dbl_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
